axi_traffic_gen: RTL and testbench
==================================

Name: axi_traffic_gen

Overview:
- Programmable AXI4 master traffic generator that drives one slave port of the XY mesh, i.e. one entry of the mesh's s_axi_i/s_axi_o arrays.
- Runs a write phase of NUM_TXN INCR bursts, then a read-back phase over the same addresses, and checks read data against a deterministic pattern.
- Reports error count and total cycle count, so 16 instances form a self-checking throughput bench.

Parameters:
- MASTER_ID, 0, AWID/ARID value driven (5 bits).
- BASE_ADDR, 16'h0000, start address of the first burst.
- BURST_LEN, 3, AWLEN/ARLEN value (beats = BURST_LEN+1).
- NUM_TXN, 8, bursts per phase (1..255).
- MAX_OUTSTANDING, 4, maximum issued-but-unretired bursts per phase (1..15).
- SEED, 8'hA5, data pattern seed.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; ignored unless in IDLE or DONE
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  high in DONE until the next start
- err_cnt  out  16  read-data mismatches, saturating
- cycle_cnt  out  32  cycles from start accept to DONE entry
- awvalid/awready  out/in  1  AW handshake; awid 5, awaddr 16, awlen 8, awsize 3 (=0), awburst 2 (=01) out
- wvalid/wready  out/in  1  W handshake; wdata 8, wstrb 1 (=1), wlast 1 out
- bvalid in 1, bid in 5, bready out 1 (tied high while busy)
- arvalid/arready  out/in  1  AR handshake; arid 5, araddr 16, arlen 8, arsize 3, arburst 2 out
- rvalid in 1, rid in 5, rdata in 8, rlast in 1, rready out 1 (tied high while busy)

Behaviour:
- Reset: every valid low, bready/rready low, done/busy low, err_cnt = 0, cycle_cnt = 0, all counters 0, state IDLE.
- Reset is asynchronous and may be asserted mid-operation: the block returns immediately to IDLE with all outputs at reset values. Any transaction in flight is abandoned.
- Burst k (0..NUM_TXN-1) address: BASE_ADDR + k*(BURST_LEN+1), mod 2^16. Beat b address = burst addr + b, also wrapping at 16 bits.
- Data for a beat: (beat_addr[7:0] ^ SEED), in both phases.
- States:
  - IDLE: start -> WR (clear counters and err_cnt, cycle_cnt = 0).
  - WR: AW and W issue in order. awvalid rises when aw_issued < NUM_TXN and outstanding < MAX_OUTSTANDING. W beats for burst k start only after AW k has handshaked. wlast marks beat BURST_LEN.
  - WR -> RD when b_count == NUM_TXN.
  - RD: arvalid rises when ar_issued < NUM_TXN and outstanding < MAX_OUTSTANDING. Each R beat is compared against the expected beat, in order.
  - RD -> DONE when the rlast count == NUM_TXN.
  - DONE: done = 1; start -> WR.
- Valid/payload stay stable until the handshake completes (AXI rule); valid is never dropped without ready.
- outstanding counter:
  - +1 on AW (AR) handshake; -1 on B (last R) handshake.
  - On the same cycle, simultaneous +1/-1 leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Error rules, each adding +1 to err_cnt (saturating at 16'hFFFF):
  - B or R with wrong id.
  - rdata mismatch.
  - rlast asserted early or missing on beat BURST_LEN.
- Unexpected B/R in IDLE/DONE: ignored, since ready is low.
- cycle_cnt increments every cycle while busy, saturating at 32'hFFFF_FFFF.

Decomposition:
- Shared noc package: AXI field widths (ID 5, ADDR 16, LEN 8, DATA 8), burst encoding constants, and the gen state enum.
- One sub-module, tg_addr_seq: burst/beat address and expected-data generator. It is instantiated twice, for the write stream and the read-compare stream.

Test Plan:
- Ideal slave (always ready, B/R one cycle later), NUM_TXN=8, BURST_LEN=3 -> 8 AW, 32 W, 8 B, 8 AR, 32 R; err_cnt = 0; done = 1; first awaddr 0x0000, last 0x001C.
- Slave holds awready low 5 cycles -> awvalid/awaddr stable throughout; no W beat for that burst before the AW handshake.
- Slave withholds B; MAX_OUTSTANDING=2 -> exactly 2 AW issued, then awvalid low until a B arrives.
- BASE_ADDR=16'hFFFC, BURST_LEN=7 -> beat addresses wrap 0xFFFF -> 0x0000; wdata = addr[7:0]^0xA5; err_cnt = 0.
- Slave corrupts rdata of one beat and returns wrong rid on another -> err_cnt = 2 at DONE.
- areset asserted mid-WR with awvalid high -> all outputs reset asynchronously the same cycle; a new start completes cleanly with err_cnt = 0.

Source files
------------

// File: rtl/axi_traffic_gen_pkg.sv
// Shared definitions for the mesh traffic generator: AXI field widths,
// burst encodings and the generator state type.
package axi_traffic_gen_pkg;

    localparam int ID_W   = 5;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 8;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_1B    = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_DONE
    } gen_state_t;

    // The same pattern is written and later expected back, so both streams share it.
    function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] seed);
        return addr[DATA_W-1:0] ^ seed;
    endfunction

endpackage

// File: rtl/tg_addr_seq.sv
// Burst/beat address walker: yields the next burst start address and, per beat,
// the last-beat flag and the data pattern for that beat.
module tg_addr_seq
    import axi_traffic_gen_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                BURST_LEN = 3,
    parameter logic [DATA_W-1:0] SEED      = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              burst_step,
    input  logic              beat_step,
    output logic [ADDR_W-1:0] burst_addr,
    output logic              beat_last,
    output logic [DATA_W-1:0] exp_data
);

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BURST_LEN + 1);
    localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(BURST_LEN);

    logic [ADDR_W-1:0] beat_addr;
    logic [LEN_W-1:0]  beat_idx;

    // Bursts are contiguous, so the beat address simply runs on by one across bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_addr <= BASE_ADDR;
            beat_addr  <= BASE_ADDR;
            beat_idx   <= '0;
        end else if (clear) begin
            burst_addr <= BASE_ADDR;
            beat_addr  <= BASE_ADDR;
            beat_idx   <= '0;
        end else begin
            if (burst_step)
                burst_addr <= burst_addr + STEP;
            if (beat_step) begin
                beat_addr <= beat_addr + 16'd1;
                beat_idx  <= beat_last ? '0 : beat_idx + 8'd1;
            end
        end
    end

    assign beat_last = (beat_idx == LAST_IDX);
    assign exp_data  = beat_data(beat_addr, SEED);

endmodule

// File: rtl/axi_traffic_gen.sv
// AXI4 master traffic generator: writes NUM_TXN INCR bursts, reads them back,
// and counts read-data/protocol mismatches plus total busy cycles.
module axi_traffic_gen
    import axi_traffic_gen_pkg::*;
#(
    parameter int                MASTER_ID       = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = 16'h0000,
    parameter int                BURST_LEN       = 3,
    parameter int                NUM_TXN         = 8,
    parameter int                MAX_OUTSTANDING = 4,
    parameter logic [DATA_W-1:0] SEED            = 8'hA5
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [31:0]       cycle_cnt,
    output logic              awvalid,
    input  logic              awready,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic              wstrb,
    output logic              wlast,
    input  logic              bvalid,
    input  logic [ID_W-1:0]   bid,
    output logic              bready,
    output logic              arvalid,
    input  logic              arready,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    output logic              rready
);

    localparam logic [ID_W-1:0]  ID      = ID_W'(MASTER_ID);
    localparam logic [7:0]       TXN     = 8'(NUM_TXN);
    localparam logic [3:0]       MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [LEN_W-1:0] LEN     = LEN_W'(BURST_LEN);

    gen_state_t state, state_next;

    logic [7:0]  aw_count, w_burst_count, b_count, ar_count, rl_count;
    logic [3:0]  outstanding;
    logic        start_accept, issue_ok;
    logic        aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic        out_inc, out_dec;
    logic [1:0]  err_add;
    logic [16:0] err_sum;
    logic        rd_beat_last;
    logic [DATA_W-1:0] rd_exp;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        arvalid    = 1'b0;
        bready     = 1'b0;
        rready     = 1'b0;
        issue_ok   = (outstanding < MAX_OUT);
        case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_WR;
            end
            ST_WR: begin
                busy    = 1'b1;
                bready  = 1'b1;
                rready  = 1'b1;
                awvalid = (aw_count < TXN) && issue_ok;
                // A burst's W beats may only start once its AW has been accepted.
                wvalid  = (w_burst_count < aw_count);
                if (b_count == TXN)
                    state_next = ST_RD;
            end
            ST_RD: begin
                busy    = 1'b1;
                bready  = 1'b1;
                rready  = 1'b1;
                arvalid = (ar_count < TXN) && issue_ok;
                if (rl_count == TXN)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start)
                    state_next = ST_WR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign aw_fire      = awvalid && awready;
    assign w_fire       = wvalid && wready;
    assign b_fire       = bvalid && bready && (state == ST_WR);
    assign ar_fire      = arvalid && arready;
    assign r_fire       = rvalid && rready && (state == ST_RD);
    assign out_inc      = aw_fire || ar_fire;
    assign out_dec      = b_fire || (r_fire && rlast);

    always_comb begin
        err_add = 2'd0;
        if (b_fire && (bid != ID))
            err_add = 2'd1;
        if (r_fire)
            err_add = 2'(rid != ID) + 2'(rdata != rd_exp) + 2'(rlast != rd_beat_last);
    end

    assign err_sum = {1'b0, err_cnt} + 17'(err_add);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_count      <= '0;
            w_burst_count <= '0;
            b_count       <= '0;
            ar_count      <= '0;
            rl_count      <= '0;
            outstanding   <= '0;
            err_cnt       <= '0;
            cycle_cnt     <= '0;
        end else if (start_accept) begin
            aw_count      <= '0;
            w_burst_count <= '0;
            b_count       <= '0;
            ar_count      <= '0;
            rl_count      <= '0;
            outstanding   <= '0;
            err_cnt       <= '0;
            cycle_cnt     <= '0;
        end else begin
            if (aw_fire)
                aw_count <= aw_count + 8'd1;
            if (w_fire && wlast)
                w_burst_count <= w_burst_count + 8'd1;
            if (b_fire)
                b_count <= b_count + 8'd1;
            if (ar_fire)
                ar_count <= ar_count + 8'd1;
            if (r_fire && rlast)
                rl_count <= rl_count + 8'd1;
            if ((state == ST_WR) && (state_next == ST_RD))
                outstanding <= '0;
            else if (out_inc && !out_dec)
                outstanding <= outstanding + 4'd1;
            else if (out_dec && !out_inc)
                outstanding <= outstanding - 4'd1;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (busy && (cycle_cnt != 32'hFFFF_FFFF))
                cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    tg_addr_seq #(
        .BASE_ADDR (BASE_ADDR),
        .BURST_LEN (BURST_LEN),
        .SEED      (SEED)
    ) u_wr_seq (
        .clk        (aclk),
        .rst        (areset),
        .clear      (start_accept),
        .burst_step (aw_fire),
        .beat_step  (w_fire),
        .burst_addr (awaddr),
        .beat_last  (wlast),
        .exp_data   (wdata)
    );

    tg_addr_seq #(
        .BASE_ADDR (BASE_ADDR),
        .BURST_LEN (BURST_LEN),
        .SEED      (SEED)
    ) u_rd_seq (
        .clk        (aclk),
        .rst        (areset),
        .clear      (start_accept),
        .burst_step (ar_fire),
        .beat_step  (r_fire),
        .burst_addr (araddr),
        .beat_last  (rd_beat_last),
        .exp_data   (rd_exp)
    );

    assign awid    = ID;
    assign awlen   = LEN;
    assign awsize  = SIZE_1B;
    assign awburst = BURST_INCR;
    assign wstrb   = 1'b1;
    assign arid    = ID;
    assign arlen   = LEN;
    assign arsize  = SIZE_1B;
    assign arburst = BURST_INCR;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Bench for axi_traffic_gen: a randomised memory slave, an expectation
// scoreboard built from address arithmetic, and a separate handshake monitor.
module tb_axi_traffic_gen;

    localparam logic [4:0]  ID   = 5'd3;
    localparam logic [15:0] BASE = 16'hFFF2;
    localparam int          BL   = 3;
    localparam int          NUM  = 8;
    localparam int          MAXO = 2;
    localparam logic [7:0]  SEED = 8'hA5;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] err_cnt;
    logic [31:0] cycle_cnt;
    logic        awvalid, awready = 1'b0;
    logic [4:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready = 1'b0;
    logic [7:0]  wdata;
    logic        wstrb, wlast;
    logic        bvalid = 1'b0;
    logic [4:0]  bid = 5'd0;
    logic        bready;
    logic        arvalid, arready = 1'b0;
    logic [4:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic [4:0]  rid = 5'd0;
    logic [7:0]  rdata = 8'd0;
    logic        rlast = 1'b0;
    logic        rready;

    always #5 aclk = ~aclk;

    axi_traffic_gen #(
        .MASTER_ID       (3),
        .BASE_ADDR       (BASE),
        .BURST_LEN       (BL),
        .NUM_TXN         (NUM),
        .MAX_OUTSTANDING (MAXO),
        .SEED            (SEED)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .cycle_cnt (cycle_cnt),
        .awvalid   (awvalid),
        .awready   (awready),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .bvalid    (bvalid),
        .bid       (bid),
        .bready    (bready),
        .arvalid   (arvalid),
        .arready   (arready),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rid       (rid),
        .rdata     (rdata),
        .rlast     (rlast),
        .rready    (rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [33:0] aw_exp[$];
    logic [33:0] ar_exp[$];
    logic [9:0]  w_exp[$];

    logic [7:0]  mem [0:65535];
    int          cyc = 0;
    int          aw_pct = 100, w_pct = 100, ar_pct = 100;
    int          b_delay_max = 0, r_delay_max = 0;
    int          hold_until = 0;
    int          inj_data = -1, inj_id = -1;
    int          r_glob = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: got unexpected event, expected none", name);
    endtask

    // Slave: picks readies/valids at each negedge; a handshake seen here lands on the next posedge.
    always @(negedge aclk) begin : slave
        logic [15:0] wq[$];
        logic [15:0] rq[$];
        int          b_due[$];
        int          r_due[$];
        int          w_beat, r_beat;
        logic [15:0] a;
        cyc++;
        if (areset) begin
            awready = 1'b0; wready = 1'b0; arready = 1'b0;
            bvalid = 1'b0; rvalid = 1'b0; bid = '0; rid = '0; rdata = '0; rlast = 1'b0;
            wq.delete(); rq.delete(); b_due.delete(); r_due.delete();
            w_beat = 0; r_beat = 0; r_glob = 0;
        end else begin
            awready = (cyc < hold_until) ? 1'b0 : ($urandom_range(99) < aw_pct);
            if (awvalid && awready)
                wq.push_back(awaddr);
            wready = ($urandom_range(99) < w_pct);
            if (wvalid && wready) begin
                a = (wq.size() > 0 ? wq[0] : 16'h0) + 16'(w_beat);
                mem[a] = wdata;
                if (w_beat == BL) begin
                    if (wq.size() > 0) void'(wq.pop_front());
                    w_beat = 0;
                    b_due.push_back(cyc + 1 + int'($urandom_range(b_delay_max)));
                end else begin
                    w_beat++;
                end
            end
            bvalid = (b_due.size() > 0) && (b_due[0] <= cyc);
            bid = ID;
            if (bvalid && bready)
                void'(b_due.pop_front());
            arready = ($urandom_range(99) < ar_pct);
            if (arvalid && arready) begin
                rq.push_back(araddr);
                r_due.push_back(cyc + 1 + int'($urandom_range(r_delay_max)));
            end
            rvalid = (rq.size() > 0) && (r_due[0] <= cyc);
            if (rvalid) begin
                a = rq[0] + 16'(r_beat);
                rdata = mem[a] ^ ((r_glob == inj_data) ? 8'h40 : 8'h00);
                rid = (r_glob == inj_id) ? (ID ^ 5'h01) : ID;
                rlast = (r_beat == BL);
            end else begin
                rdata = '0; rid = '0; rlast = 1'b0;
            end
            if (rvalid && rready) begin
                r_glob++;
                if (r_beat == BL) begin
                    void'(rq.pop_front());
                    void'(r_due.pop_front());
                    r_beat = 0;
                end else begin
                    r_beat++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every master-side handshake and checks AXI ordering rules.
    always begin : monitor
        int          aw_hs, b_hs, w_done;
        logic        aw_stall, ar_stall;
        logic [15:0] aw_addr_q, ar_addr_q;
        @(negedge aclk);
        #2;
        if (areset) begin
            aw_hs = 0; b_hs = 0; w_done = 0;
            aw_stall = 1'b0; ar_stall = 1'b0;
            aw_addr_q = '0; ar_addr_q = '0;
        end else begin
            if (wvalid)
                check_output("w_after_aw", 64'(aw_hs > w_done), 64'd1);
            if (aw_stall) begin
                check_output("aw_stable_valid", awvalid, 1'b1);
                check_output("aw_stable_addr", awaddr, aw_addr_q);
            end
            if (ar_stall) begin
                check_output("ar_stable_valid", arvalid, 1'b1);
                check_output("ar_stable_addr", araddr, ar_addr_q);
            end
            if (awvalid && awready) begin
                check_output("aw_outstanding", 64'((aw_hs - b_hs) < MAXO), 64'd1);
                if (aw_exp.size() == 0) report_fail("aw_extra");
                else check_output("aw", {awid, awaddr, awlen, awsize, awburst}, aw_exp.pop_front());
                aw_hs++;
            end
            if (wvalid && wready) begin
                if (w_exp.size() == 0) report_fail("w_extra");
                else check_output("w", {wdata, wlast, wstrb}, w_exp.pop_front());
                if (wlast) w_done++;
            end
            if (bvalid && bready)
                b_hs++;
            if (arvalid && arready) begin
                if (ar_exp.size() == 0) report_fail("ar_extra");
                else check_output("ar", {arid, araddr, arlen, arsize, arburst}, ar_exp.pop_front());
            end
            aw_stall  = awvalid && !awready;
            ar_stall  = arvalid && !arready;
            aw_addr_q = awaddr;
            ar_addr_q = araddr;
        end
    end

    task automatic build_expect();
        aw_exp.delete();
        ar_exp.delete();
        w_exp.delete();
        for (int k = 0; k < NUM; k++) begin
            logic [15:0] a;
            a = BASE + 16'(k * (BL + 1));
            aw_exp.push_back({ID, a, 8'(BL), 3'b000, 2'b01});
            ar_exp.push_back({ID, a, 8'(BL), 3'b000, 2'b01});
            for (int b = 0; b <= BL; b++) begin
                logic [15:0] ba;
                ba = a + 16'(b);
                w_exp.push_back({ba[7:0] ^ SEED, (b == BL), 1'b1});
            end
        end
    endtask

    task automatic apply_stimulus(input int awp, input int wp, input int arp,
                                  input int bmax, input int rmax, input int hold,
                                  input int n_inj);
        int n;
        int exp_err;
        aw_pct = awp; w_pct = wp; ar_pct = arp;
        b_delay_max = bmax; r_delay_max = rmax;
        hold_until = cyc + hold;
        inj_data = -1; inj_id = -1;
        exp_err = 0;
        if (n_inj > 0) begin
            inj_data = r_glob + int'($urandom_range(0, 15));
            inj_id   = r_glob + int'($urandom_range(16, 31));
            exp_err  = 2;
        end
        build_expect();
        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL done_timeout: got done=0 after %0d cycles, expected done=1", n);
        end else begin
            check_output("err_cnt", err_cnt, 64'(exp_err));
            check_output("cycle_cnt", cycle_cnt, 64'(n));
            check_output("busy_at_done", busy, 1'b0);
            check_output("aw_left", 64'(aw_exp.size()), 64'd0);
            check_output("w_left", 64'(w_exp.size()), 64'd0);
            check_output("ar_left", 64'(ar_exp.size()), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        $display("[TB] reset checks: %s", tag);
        check_output("rst_awvalid", awvalid, 1'b0);
        check_output("rst_wvalid", wvalid, 1'b0);
        check_output("rst_arvalid", arvalid, 1'b0);
        check_output("rst_bready", bready, 1'b0);
        check_output("rst_rready", rready, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_err_cnt", err_cnt, 16'd0);
        check_output("rst_cycle_cnt", cycle_cnt, 32'd0);
    endtask

    task automatic reset_mid_write();
        int n;
        aw_pct = 100; w_pct = 100; ar_pct = 100;
        b_delay_max = 0; r_delay_max = 0;
        build_expect();
        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (4) @(negedge aclk);
        n = 0;
        while (!awvalid && n < 200) begin
            @(negedge aclk);
            n++;
        end
        #1;
        if (!awvalid) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL mid_wr_awvalid: got awvalid=0, expected 1 before reset");
        end
        areset = 1'b1;
        #1;
        check_reset_outputs("mid-write");
        repeat (3) @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        check_reset_outputs("power-on");
        areset = 1'b0;
        $display("[TB] run: ideal slave");
        apply_stimulus(100, 100, 100, 0, 0, 0, 0);
        $display("[TB] run: stalls, withheld B, two injected read errors");
        apply_stimulus(60, 70, 50, 25, 6, 7, 1);
        $display("[TB] run: reset during write phase");
        reset_mid_write();
        apply_stimulus(80, 80, 80, 3, 3, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
